leds_ram_dp: RTL and testbench
==============================

# leds_ram_dp

Parametrised dual-port on-chip RAM for the Nios II LED system, successor to the single-port program/data RAM. It exposes two independent Avalon-MM slaves (s1 for the instruction master, s2 for the data master or a DMA) over one inferred memory array. It adds configurable width and depth, selectable read latency with `readdatavalid`, and deterministic same-address collision handling via `s2_waitrequest`.

## Interface
- `DATA_WIDTH`, 32: word width; a multiple of 8.
- `DEPTH`, 5120: number of words.
- `ADDR_WIDTH`, 13: word-address width; `2**ADDR_WIDTH >= DEPTH`.
- `READ_LATENCY`, 1: 1 or 2 cycles from accepted read to `readdatavalid`; other values are an elaboration error.
- `INIT_FILE`, "leds_ram.hex": power-up memory contents.
- `clk`  in  1  single clock for both ports.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  global clock enable.
- `reset_req`  in  1  freeze request; freezes the block like `clken`=0.
- `s1_address` / `s2_address`  in  `ADDR_WIDTH`  word address.
- `s1_chipselect` / `s2_chipselect`  in  1  port select.
- `s1_read` / `s2_read`  in  1  read strobe.
- `s1_write` / `s2_write`  in  1  write strobe.
- `s1_byteenable` / `s2_byteenable`  in  `DATA_WIDTH/8`  byte-lane write enables.
- `s1_writedata` / `s2_writedata`  in  `DATA_WIDTH`  write data.
- `s1_readdata` / `s2_readdata`  out  `DATA_WIDTH`  read data.
- `s1_readdatavalid` / `s2_readdatavalid`  out  1  read data valid.
- `s1_waitrequest`  out  1  stall for s1; asserted only when frozen.
- `s2_waitrequest`  out  1  stall for s2; asserted when frozen or on collision.

## Operation
- Freeze condition: `frz = ~clken | reset_req`.
- Request validity:
  - `req1 = s1_chipselect & (s1_read | s1_write)`; `req2` is the same for s2.
  - Accepted means the request is valid and the port's `waitrequest` is 0.
- Collision: `coll = req1 & req2 & (s1_address == s2_address) & (s1_write | s2_write)`.
- Waitrequest:
  - `s2_waitrequest = frz | coll`.
  - `s1_waitrequest = frz`.
  - Both are combinational; s1 always has priority.
  - s2 must hold its request stable until accepted. It completes on the first non-colliding, non-frozen cycle.
  - Result: an s2 read after a colliding s1 write returns the new data. An s1 read colliding with an s2 write returns the old data.
- Writes:
  - Only lanes with `byteenable[i]=1` are updated (bits `8i+7:8i`).
  - `byteenable=0` is accepted with no effect.
- Simultaneous read and write on one port: the write is performed and the read is dropped; no `readdatavalid` is produced.
- Out-of-range address (`>= DEPTH`):
  - Writes are accepted and discarded.
  - Reads are accepted and return all-zero data with `readdatavalid`.
- Read pipeline:
  - Each port has a `READ_LATENCY`-deep valid/data shift pipeline.
  - All pipeline stages and the memory clock enable hold while `frz`=1.
  - `readdatavalid` is forced to 0 while `frz`=1. Held entries re-emerge once `frz` falls; none are lost or duplicated.
- `readdata` holds its last valid value while `readdatavalid`=0.
- Memory contents:
  - Not affected by `reset_n`.
  - Initialised from `INIT_FILE` at configuration only.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - `s1_readdata`, `s2_readdata` = 0.
  - `s1_readdatavalid`, `s2_readdatavalid` = 0.
  - All pipeline valids are cleared, so in-flight reads are discarded and never return.
  - `waitrequest` outputs follow their combinational equations.
- Deassertion of `reset_n` is synchronised externally; the first request is accepted on the first edge after deassertion.
- Read accepted in cycle T returns `readdata`/`readdatavalid` at T+`READ_LATENCY` (absent freeze). Each cycle of `frz` in between adds one cycle.
- Write accepted in cycle T takes effect at the end of T. A read of the same address accepted at T+1, on either port, returns the new data.
- Throughput: one access per port per cycle; back-to-back reads produce back-to-back valids.
- A collision costs s2 exactly one cycle per colliding s1 access.

## Test plan
- Reset and basic access: after reset, check all outputs are 0. s1 writes 0xDEADBEEF to address 5 with byteenable 0xF. s2 reads address 5 at T+1. Expect `s2_readdata`=0xDEADBEEF with valid at T+1+`READ_LATENCY`.
- Byte lanes:
  - Write 0x11223344 with byteenable 0xF, then 0xAABBCCDD with byteenable 0x5.
  - Read back: expect 0x11BB33DD.
- Collision: same cycle, s1 writes 0x12345678 to address 9 and s2 reads address 9. Expect `s2_waitrequest`=1 for one cycle, then s2 returns 0x12345678. Repeat with s2 writing: s1 reads the old value and the s2 write lands one cycle later.
- Freeze: issue back-to-back s1 reads of addresses 0..3. Drop `clken` for 3 cycles mid-stream. Expect no valid during the freeze, then exactly four valids in order with correct data; repeat with `reset_req`.
- Reset mid-operation: accept a read at `READ_LATENCY`=2, then assert `reset_n`=0 one cycle later. Expect no `readdatavalid` ever for that read; memory contents are intact afterwards.
- Bounds: read address `DEPTH` and expect 0 with valid; write to `DEPTH`, then read address 0 and expect it unchanged. Run all tests at `READ_LATENCY` 1 and 2 and at `DATA_WIDTH` 16.

Source files
------------

// File: rtl/leds_ram_dp.sv
// -----------------------------------------------------------------------------
// leds_ram_dp
//
// Dual-port on-chip RAM for the Nios II LED system. Two independent Avalon-MM
// slaves share one memory array: s1 serves the instruction master, s2 the data
// master or a DMA. Both ports run on one clock.
//
// Handshake: a port request is valid when chipselect & (read | write). It is
// accepted in any cycle where it is valid and that port's waitrequest is 0.
// While waitrequest is 1 the master holds address/strobes/data stable. Read
// data comes back READ_LATENCY accepted cycles later, flagged by
// readdatavalid. Write data is in the array at the end of the accepting cycle.
//
// Parameters
//   DATA_WIDTH   word width, a multiple of 8
//   DEPTH        number of words
//   ADDR_WIDTH   word-address width, 2**ADDR_WIDTH >= DEPTH
//   READ_LATENCY 1 or 2
//   INIT_FILE    power-up contents, applied by the device's RAM-init flow
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   clken, reset_req      global enable / freeze request (either freezes)
//   sN_address            word address
//   sN_chipselect         port select
//   sN_read, sN_write     strobes; read+write together performs only the write
//   sN_byteenable         byte-lane write enables
//   sN_writedata          write data
//   sN_readdata           read data (holds last valid value)
//   sN_readdatavalid      read data valid
//   sN_waitrequest        stall; s2 also stalls on a same-address collision
// -----------------------------------------------------------------------------
module leds_ram_dp #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 5120,
   parameter int ADDR_WIDTH   = 13,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = "leds_ram.hex"
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clken,
   input  logic                    reset_req,
   input  logic [ADDR_WIDTH-1:0]   s1_address,
   input  logic                    s1_chipselect,
   input  logic                    s1_read,
   input  logic                    s1_write,
   input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
   input  logic [DATA_WIDTH-1:0]   s1_writedata,
   output logic [DATA_WIDTH-1:0]   s1_readdata,
   output logic                    s1_readdatavalid,
   output logic                    s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]   s2_address,
   input  logic                    s2_chipselect,
   input  logic                    s2_read,
   input  logic                    s2_write,
   input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
   input  logic [DATA_WIDTH-1:0]   s2_writedata,
   output logic [DATA_WIDTH-1:0]   s2_readdata,
   output logic                    s2_readdatavalid,
   output logic                    s2_waitrequest
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("leds_ram_dp: READ_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("leds_ram_dp: DATA_WIDTH must be a multiple of 8");
   end

   (* ram_init_file = INIT_FILE *)
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Port signals gathered into arrays so both ports share one description.
   logic [ADDR_WIDTH-1:0] w_addr  [2];
   logic [NB-1:0]         w_be    [2];
   logic [DATA_WIDTH-1:0] w_wdata [2];
   logic [IDX_W-1:0]      w_idx   [2];
   logic [DATA_WIDTH-1:0] w_rdata [2];
   logic [DATA_WIDTH-1:0] w_rdout [2];
   logic [1:0]            w_req;
   logic [1:0]            w_acc;
   logic [1:0]            w_wr;
   logic [1:0]            w_rd;
   logic [1:0]            w_in;
   logic [1:0]            w_dv;
   logic                  w_frz;
   logic                  w_coll;

   assign w_addr[0]  = s1_address;
   assign w_addr[1]  = s2_address;
   assign w_be[0]    = s1_byteenable;
   assign w_be[1]    = s2_byteenable;
   assign w_wdata[0] = s1_writedata;
   assign w_wdata[1] = s2_writedata;

   assign w_frz    = ~clken | reset_req;
   assign w_req[0] = s1_chipselect & (s1_read | s1_write);
   assign w_req[1] = s2_chipselect & (s2_read | s2_write);

   // Same word touched by both ports with at least one write: s1 wins, s2
   // waits one cycle. This also means the two ports never write the same
   // word in one cycle, and a read never sees a same-cycle write.
   assign w_coll = w_req[0] & w_req[1] & (s1_address == s2_address)
                 & (s1_write | s2_write);

   assign s1_waitrequest = w_frz;
   assign s2_waitrequest = w_frz | w_coll;

   assign w_acc[0] = w_req[0] & ~s1_waitrequest;
   assign w_acc[1] = w_req[1] & ~s2_waitrequest;
   assign w_wr[0]  = w_acc[0] & s1_write;
   assign w_wr[1]  = w_acc[1] & s2_write;
   // A read issued together with a write on the same port is dropped.
   assign w_rd[0]  = w_acc[0] & s1_read & ~s1_write;
   assign w_rd[1]  = w_acc[1] & s2_read & ~s2_write;

   for (genvar p = 0; p < 2; p++) begin : g_addr
      assign w_in[p]    = ({1'b0, w_addr[p]} < C_DEPTH);
      assign w_idx[p]   = w_addr[p][IDX_W-1:0];
      // Out-of-range reads return zero.
      assign w_rdata[p] = w_in[p] ? r_mem[w_idx[p]] : '0;
   end

   // Memory array: no reset, contents survive reset_n. Out-of-range writes
   // are accepted and dropped here.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (w_wr[p] && w_in[p]) begin
            for (int b = 0; b < NB; b++) begin
               if (w_be[p][b]) begin
                  r_mem[w_idx[p]][8*b +: 8] <= w_wdata[p][8*b +: 8];
               end
            end
         end
      end
   end

   // Per-port read pipeline. Stages advance only while not frozen, so held
   // entries re-emerge once the freeze lifts. r_last keeps readdata steady
   // between valid beats.
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [READ_LATENCY-1:0] r_vld;
      logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];
      logic [DATA_WIDTH-1:0]   r_last;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
               r_dat[k] <= '0;
            end
         end else begin
            if (w_dv[p]) begin
               r_last <= r_dat[READ_LATENCY-1];
            end
            if (!w_frz) begin
               r_vld[0] <= w_rd[p];
               if (w_rd[p]) begin
                  r_dat[0] <= w_rdata[p];
               end
               for (int k = 1; k < READ_LATENCY; k++) begin
                  r_vld[k] <= r_vld[k-1];
                  if (r_vld[k-1]) begin
                     r_dat[k] <= r_dat[k-1];
                  end
               end
            end
         end
      end

      assign w_dv[p]    = r_vld[READ_LATENCY-1] & ~w_frz;
      assign w_rdout[p] = w_dv[p] ? r_dat[READ_LATENCY-1] : r_last;
   end

   assign s1_readdata      = w_rdout[0];
   assign s2_readdata      = w_rdout[1];
   assign s1_readdatavalid = w_dv[0];
   assign s2_readdatavalid = w_dv[1];

endmodule

// File: tb/tb_leds_ram_dp.sv
// -----------------------------------------------------------------------------
// tb_leds_ram_dp
//
// Two instances share all stimulus: u_a (32-bit, READ_LATENCY 1) and u_b
// (16-bit, READ_LATENCY 2, fed the low half of data and byte enables). A
// 32-bit reference memory predicts both; u_b expects its low 16 bits.
// -----------------------------------------------------------------------------
module tb_leds_ram_dp;

   localparam int DEPTH = 48;
   localparam int AW    = 6;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n   = 1'b0;
   logic clken     = 1'b1;
   logic reset_req = 1'b0;

   logic          s1_cs = 0, s1_rd = 0, s1_wr = 0;
   logic [AW-1:0] s1_addr = '0;
   logic [3:0]    s1_be = '0;
   logic [31:0]   s1_wd = '0;
   logic          s2_cs = 0, s2_rd = 0, s2_wr = 0;
   logic [AW-1:0] s2_addr = '0;
   logic [3:0]    s2_be = '0;
   logic [31:0]   s2_wd = '0;

   logic [31:0] a_s1_rdata, a_s2_rdata;
   logic        a_s1_rdv, a_s2_rdv, a_s1_wr, a_s2_wr;
   logic [15:0] b_s1_rdata, b_s2_rdata;
   logic        b_s1_rdv, b_s2_rdv, b_s1_wr, b_s2_wr;

   leds_ram_dp #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
                 .READ_LATENCY(1), .INIT_FILE("")) u_a (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_addr), .s1_chipselect(s1_cs), .s1_read(s1_rd),
      .s1_write(s1_wr), .s1_byteenable(s1_be), .s1_writedata(s1_wd),
      .s1_readdata(a_s1_rdata), .s1_readdatavalid(a_s1_rdv),
      .s1_waitrequest(a_s1_wr),
      .s2_address(s2_addr), .s2_chipselect(s2_cs), .s2_read(s2_rd),
      .s2_write(s2_wr), .s2_byteenable(s2_be), .s2_writedata(s2_wd),
      .s2_readdata(a_s2_rdata), .s2_readdatavalid(a_s2_rdv),
      .s2_waitrequest(a_s2_wr)
   );

   leds_ram_dp #(.DATA_WIDTH(16), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
                 .READ_LATENCY(2), .INIT_FILE("")) u_b (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_addr), .s1_chipselect(s1_cs), .s1_read(s1_rd),
      .s1_write(s1_wr), .s1_byteenable(s1_be[1:0]), .s1_writedata(s1_wd[15:0]),
      .s1_readdata(b_s1_rdata), .s1_readdatavalid(b_s1_rdv),
      .s1_waitrequest(b_s1_wr),
      .s2_address(s2_addr), .s2_chipselect(s2_cs), .s2_read(s2_rd),
      .s2_write(s2_wr), .s2_byteenable(s2_be[1:0]), .s2_writedata(s2_wd[15:0]),
      .s2_readdata(b_s2_rdata), .s2_readdatavalid(b_s2_rdv),
      .s2_waitrequest(b_s2_wr)
   );

   // scoreboard
   logic [31:0] exp_a1[$], exp_a2[$], exp_b1[$], exp_b2[$];
   logic [31:0] mdl [DEPTH];
   int checks = 0;
   int errors = 0;

   // outputs captured at the falling edge of the last stepped cycle
   logic        sn_a1v, sn_a2v, sn_b1v, sn_b2v, sn_a1w, sn_a2w, sn_b1w, sn_b2w;
   logic [31:0] sn_a1d;
   logic [15:0] sn_b1d;
   logic        last_acc2;

   function automatic logic [31:0] mdl_read(input logic [AW-1:0] a);
      return (a < DEPTH) ? mdl[a] : 32'h0;
   endfunction

   task automatic mdl_write(input logic [AW-1:0] a, input logic [3:0] be,
                            input logic [31:0] d);
      if (a < DEPTH) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic sb_one(input string nm, input logic v, input logic [31:0] d,
                         ref logic [31:0] q[$]);
      logic [31:0] e;
      if (v) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected valid got=%h expected=none", nm, d);
         end else begin
            e = q.pop_front();
            if (d !== e) begin
               errors++;
               $display("FAIL %s got=%h expected=%h", nm, d, e);
            end
         end
      end
   endtask

   // driver tasks
   task automatic drv1(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] d);
      s1_cs = rd | wr; s1_rd = rd; s1_wr = wr; s1_addr = a; s1_be = be; s1_wd = d;
   endtask

   task automatic drv2(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] d);
      s2_cs = rd | wr; s2_rd = rd; s2_wr = wr; s2_addr = a; s2_be = be; s2_wd = d;
   endtask

   task automatic idle();
      drv1(0, 0, '0, '0, '0);
      drv2(0, 0, '0, '0, '0);
   endtask

   // One clock cycle: predict acceptance from the driven inputs, check the
   // outputs at the falling edge, then update the reference model.
   task automatic step();
      logic frz, r1, r2, coll, acc1, acc2;
      frz  = ~clken | reset_req;
      r1   = s1_cs & (s1_rd | s1_wr);
      r2   = s2_cs & (s2_rd | s2_wr);
      coll = r1 & r2 & (s1_addr == s2_addr) & (s1_wr | s2_wr);
      acc1 = r1 & ~frz;
      acc2 = r2 & ~frz & ~coll;
      @(negedge clk);
      sn_a1v = a_s1_rdv; sn_a2v = a_s2_rdv; sn_b1v = b_s1_rdv; sn_b2v = b_s2_rdv;
      sn_a1w = a_s1_wr;  sn_a2w = a_s2_wr;  sn_b1w = b_s1_wr;  sn_b2w = b_s2_wr;
      sn_a1d = a_s1_rdata; sn_b1d = b_s1_rdata;
      sb_one("a_s1_rdata", a_s1_rdv, a_s1_rdata, exp_a1);
      sb_one("a_s2_rdata", a_s2_rdv, a_s2_rdata, exp_a2);
      sb_one("b_s1_rdata", b_s1_rdv, {16'h0, b_s1_rdata}, exp_b1);
      sb_one("b_s2_rdata", b_s2_rdv, {16'h0, b_s2_rdata}, exp_b2);
      // reads see the contents from before this cycle's writes
      if (acc1 && s1_rd && !s1_wr) begin
         exp_a1.push_back(mdl_read(s1_addr));
         exp_b1.push_back({16'h0, mdl_read(s1_addr) & 32'hFFFF});
      end
      if (acc2 && s2_rd && !s2_wr) begin
         exp_a2.push_back(mdl_read(s2_addr));
         exp_b2.push_back({16'h0, mdl_read(s2_addr) & 32'hFFFF});
      end
      if (acc1 && s1_wr) mdl_write(s1_addr, s1_be, s1_wd);
      if (acc2 && s2_wr) mdl_write(s2_addr, s2_be, s2_wd);
      last_acc2 = acc2;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      idle();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_empty(input string nm);
      checks++;
      if (exp_a1.size() + exp_a2.size() + exp_b1.size() + exp_b2.size() != 0) begin
         errors++;
         $display("FAIL %s outstanding reads a1=%0d a2=%0d b1=%0d b2=%0d expected=0",
                  nm, exp_a1.size(), exp_a2.size(), exp_b1.size(), exp_b2.size());
      end
   endtask

   // tests
   task automatic test_reset();
      reset_n = 0;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a_s1_rdata, a_s2_rdata, a_s1_rdv, a_s2_rdv, a_s1_wr, a_s2_wr} !== '0) begin
         errors++;
         $display("FAIL reset_a got=%h/%h v=%b%b w=%b%b expected=all 0",
                  a_s1_rdata, a_s2_rdata, a_s1_rdv, a_s2_rdv, a_s1_wr, a_s2_wr);
      end
      checks++;
      if ({b_s1_rdata, b_s2_rdata, b_s1_rdv, b_s2_rdv, b_s1_wr, b_s2_wr} !== '0) begin
         errors++;
         $display("FAIL reset_b got=%h/%h v=%b%b w=%b%b expected=all 0",
                  b_s1_rdata, b_s2_rdata, b_s1_rdv, b_s2_rdv, b_s1_wr, b_s2_wr);
      end
      // waitrequest stays combinational in reset
      clken = 0;
      #1;
      checks++;
      if ({a_s1_wr, a_s2_wr, b_s1_wr, b_s2_wr} !== 4'b1111) begin
         errors++;
         $display("FAIL reset_waitreq got=%b expected=1111",
                  {a_s1_wr, a_s2_wr, b_s1_wr, b_s2_wr});
      end
      clken = 1;
      @(posedge clk);
      #1;
      reset_n = 1;
   endtask

   task automatic test_basic();
      drv1(0, 1, AW'(5), 4'hF, 32'hDEADBEEF);
      step();
      idle();
      drv2(1, 0, AW'(5), 4'h0, 32'h0);
      step();
      idle();
      step();
      checks++;
      if ({sn_a2v, sn_b2v} !== 2'b10) begin
         errors++;
         $display("FAIL basic_latency_t1 got a=%b b=%b expected a=1 b=0", sn_a2v, sn_b2v);
      end
      step();
      checks++;
      if ({sn_a2v, sn_b2v} !== 2'b01) begin
         errors++;
         $display("FAIL basic_latency_t2 got a=%b b=%b expected a=0 b=1", sn_a2v, sn_b2v);
      end
      check_empty("basic_drain");
   endtask

   task automatic test_byte_lanes();
      drv2(0, 1, AW'(7), 4'hF, 32'h11223344);
      step();
      idle();
      drv1(0, 1, AW'(7), 4'h5, 32'hAABBCCDD);
      step();
      drv1(0, 1, AW'(7), 4'h0, 32'h99999999);
      step();
      drv1(1, 0, AW'(7), 4'h0, 32'h0);
      step();
      idle();
      step();
      checks++;
      if (sn_a1d !== 32'h11BB33DD) begin
         errors++;
         $display("FAIL byte_lanes_a got=%h expected=11bb33dd", sn_a1d);
      end
      step();
      checks++;
      if (sn_b1d !== 16'h33DD) begin
         errors++;
         $display("FAIL byte_lanes_b got=%h expected=33dd", sn_b1d);
      end
      // read+write on one port: write lands, read is dropped
      drv2(1, 1, AW'(7), 4'h8, 32'h55000000);
      step();
      drain(3);
      check_empty("rw_same_port");
      drv1(1, 0, AW'(7), 4'h0, 32'h0);
      step();
      drain(3);
   endtask

   task automatic test_collision();
      drv1(0, 1, AW'(9), 4'hF, 32'h12345678);
      drv2(1, 0, AW'(9), 4'h0, 32'h0);
      step();
      checks++;
      if ({sn_a1w, sn_a2w, sn_b2w} !== 3'b011) begin
         errors++;
         $display("FAIL coll_w_r_stall got s1=%b a2=%b b2=%b expected 0 1 1",
                  sn_a1w, sn_a2w, sn_b2w);
      end
      drv1(0, 0, '0, '0, '0);
      step();
      checks++;
      if ({sn_a2w, sn_b2w} !== 2'b00) begin
         errors++;
         $display("FAIL coll_w_r_release got a2=%b b2=%b expected 00", sn_a2w, sn_b2w);
      end
      drain(3);
      // s2 writes while s1 reads: s1 sees old data, s2 write lands a cycle later
      drv1(1, 0, AW'(9), 4'h0, 32'h0);
      drv2(0, 1, AW'(9), 4'hF, 32'hCAFEF00D);
      step();
      checks++;
      if ({sn_a2w, sn_b2w} !== 2'b11) begin
         errors++;
         $display("FAIL coll_r_w_stall got a2=%b b2=%b expected 11", sn_a2w, sn_b2w);
      end
      drv1(0, 0, '0, '0, '0);
      step();
      drv2(0, 0, '0, '0, '0);
      drv1(1, 0, AW'(9), 4'h0, 32'h0);
      step();
      drain(3);
      check_empty("collision_drain");
   endtask

   task automatic test_freeze(input bit use_req);
      for (int i = 0; i < 4; i++) begin
         drv1(0, 1, AW'(i), 4'hF, $urandom());
         step();
      end
      for (int i = 0; i < 2; i++) begin
         drv1(1, 0, AW'(i), 4'h0, 32'h0);
         step();
      end
      drv1(1, 0, AW'(2), 4'h0, 32'h0);
      if (use_req) reset_req = 1; else clken = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if ({sn_a1v, sn_b1v, sn_a1w, sn_b1w} !== 4'b0011) begin
            errors++;
            $display("FAIL freeze_hold req=%0d cyc=%0d got v=%b%b w=%b%b expected v=00 w=11",
                     use_req, c, sn_a1v, sn_b1v, sn_a1w, sn_b1w);
         end
      end
      reset_req = 0;
      clken = 1;
      step();
      drv1(1, 0, AW'(3), 4'h0, 32'h0);
      step();
      drain(4);
      check_empty(use_req ? "freeze_reset_req" : "freeze_clken");
   endtask

   task automatic test_reset_mid();
      drv1(0, 1, AW'(12), 4'hF, 32'hA5A5C3C3);
      step();
      drv1(1, 0, AW'(12), 4'h0, 32'h0);
      step();
      // in-flight reads are discarded by reset
      reset_n = 0;
      exp_a1.delete(); exp_a2.delete(); exp_b1.delete(); exp_b2.delete();
      idle();
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if ({sn_a1v, sn_b1v} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_valid cyc=%0d got a=%b b=%b expected 00", c, sn_a1v, sn_b1v);
         end
      end
      reset_n = 1;
      step();
      checks++;
      if ({sn_a1d, sn_b1d} !== '0) begin
         errors++;
         $display("FAIL reset_mid_rdata got a=%h b=%h expected 0", sn_a1d, sn_b1d);
      end
      drv1(1, 0, AW'(12), 4'h0, 32'h0);
      step();
      drain(3);
      check_empty("reset_mid_intact");
   endtask

   task automatic test_bounds();
      drv1(0, 1, AW'(0), 4'hF, 32'h0BADF00D);
      drv2(0, 1, AW'(DEPTH-1), 4'hF, 32'h7E577E57);
      step();
      idle();
      drv2(1, 0, AW'(DEPTH), 4'h0, 32'h0);
      step();
      drv2(0, 1, AW'(DEPTH), 4'hF, 32'hFFFFFFFF);
      drv1(1, 0, AW'(63), 4'h0, 32'h0);
      step();
      idle();
      drv1(1, 0, AW'(0), 4'h0, 32'h0);
      drv2(1, 0, AW'(DEPTH-1), 4'h0, 32'h0);
      step();
      drain(4);
      check_empty("bounds");
   endtask

   task automatic test_back_to_back();
      int op;
      for (int i = 0; i < 16; i++) begin
         drv1(0, 1, AW'(i), 4'hF, $urandom());
         step();
      end
      last_acc2 = 1;
      for (int c = 0; c < 60; c++) begin
         op = $urandom_range(0, 3);
         drv1(op[0], op[1], AW'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom());
         // s2 keeps a stalled request stable until it is accepted
         if (last_acc2 || !s2_cs) begin
            op = $urandom_range(0, 3);
            drv2(op[0], op[1], AW'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom());
         end
         step();
      end
      drain(4);
      check_empty("back_to_back");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_lanes();
      test_collision();
      test_freeze(0);
      test_freeze(1);
      test_reset_mid();
      test_bounds();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
